// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable word length, parity and stop bits.
// Bits are taken by 2-of-3 majority around mid-bit; a word completes at the last stop-bit decision.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int H  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] C_PRE = CW'(H - 1);
    localparam logic [CW-1:0] C_MID = CW'(H);
    localparam logic [CW-1:0] C_DEC = CW'(H + 1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 s_pre;
    logic                 s_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 stop_bad;

    logic vote;
    logic complete;
    logic stop_bad_word;

    always_comb begin
        vote          = (s_pre & s_mid) | (s_pre & rx_s) | (s_mid & rx_s);
        complete      = clken && (state == S_STOP) && (cnt == C_DEC) && (bit_idx == LAST_STOP);
        stop_bad_word = stop_bad | ~vote;
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rx_prev  <= 1'b1;
            bit_idx  <= '0;
            s_pre    <= 1'b1;
            s_mid    <= 1'b1;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (clken) begin
            rx_prev <= rx_s;
            if (state == S_IDLE) begin
                cnt <= '0;
                // Only a high-to-low transition starts a frame, so a held-low break yields one word.
                if (!rx_s && rx_prev) begin
                    state    <= S_START;
                    bit_idx  <= '0;
                    par_bad  <= 1'b0;
                    stop_bad <= 1'b0;
                end
            end else begin
                cnt <= cnt + CW'(1);
                if (cnt == C_PRE) s_pre <= rx_s;
                if (cnt == C_MID) s_mid <= rx_s;
                case (state)
                    S_START: begin
                        if (cnt == C_DEC && vote) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (cnt == C_END) begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (cnt == C_DEC) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (cnt == C_END) begin
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= '0;
                                state   <= (PARITY != 0) ? S_PAR : S_STOP;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end
                    S_PAR: begin
                        if (cnt == C_DEC) begin
                            par_bad <= (PARITY == 2) ? ~(^shreg ^ vote) : (^shreg ^ vote);
                        end
                        if (cnt == C_END) state <= S_STOP;
                    end
                    S_STOP: begin
                        // The final stop bit ends the frame at its decision tick, not at bit end.
                        if (cnt == C_DEC) begin
                            stop_bad <= stop_bad_word;
                            if (bit_idx == LAST_STOP) begin
                                state <= S_IDLE;
                                cnt   <= '0;
                            end
                        end else if (cnt == C_END) begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            rdy        <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            rdy        <= 1'b1;
            data       <= shreg;
            parity_err <= (PARITY != 0) ? par_bad : 1'b0;
            frame_err  <= stop_bad_word;
            // An acknowledge in the completion cycle consumes the old word, so no overrun.
            overrun    <= rdy_clr ? 1'b0 : (rdy | overrun);
        end else if (rdy_clr) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1/16x, 8E1/16x, 7O2/8x) fed framed serial data,
// with expected words queued at issue time and checked by a separate monitor.
module tb_uart_rx_param;

    logic       clk_50m;
    logic       rst_n;
    logic       clken;
    logic [2:0] rx_v;
    logic [2:0] clr_auto;
    logic [2:0] clr_man;
    logic [2:0] auto_clr;
    logic [2:0] rdy_clr_v;
    logic [2:0] rdy_v;
    logic [2:0] perr_v;
    logic [2:0] ferr_v;
    logic [2:0] ovr_v;
    logic [7:0] data_def;
    logic [7:0] data_par;
    logic [6:0] data_alt;
    logic [11:0] out_v [3];

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    logic [11:0] exp_q2[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    assign rdy_clr_v = clr_auto | clr_man;
    assign out_v[0]  = {ovr_v[0], ferr_v[0], perr_v[0], 1'b0, data_def};
    assign out_v[1]  = {ovr_v[1], ferr_v[1], perr_v[1], 1'b0, data_par};
    assign out_v[2]  = {ovr_v[2], ferr_v[2], perr_v[2], 2'b00, data_alt};

    uart_rx_param u_def (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .rx(rx_v[0]), .rdy_clr(rdy_clr_v[0]),
        .rdy(rdy_v[0]), .data(data_def), .parity_err(perr_v[0]), .frame_err(ferr_v[0]),
        .overrun(ovr_v[0])
    );

    uart_rx_param #(.PARITY(1)) u_par (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .rx(rx_v[1]), .rdy_clr(rdy_clr_v[1]),
        .rdy(rdy_v[1]), .data(data_par), .parity_err(perr_v[1]), .frame_err(ferr_v[1]),
        .overrun(ovr_v[1])
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(8)) u_alt (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .rx(rx_v[2]), .rdy_clr(rdy_clr_v[2]),
        .rdy(rdy_v[2]), .data(data_alt), .parity_err(perr_v[2]), .frame_err(ferr_v[2]),
        .overrun(ovr_v[2])
    );

    // Clock and oversample tick (every 4th cycle)
    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    initial begin
        clken = 1'b0;
        forever begin
            @(posedge clk_50m);
            #1;
            cyc++;
            clken = (cyc % 4 == 0);
        end
    end

    initial begin
        #4000000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    function automatic int nb_of(input int d);
        return (d == 2) ? 7 : 8;
    endfunction

    function automatic int os_of(input int d);
        return (d == 2) ? 8 : 16;
    endfunction

    function automatic int ns_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    function automatic int pm_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic push_exp(input int d, input logic [11:0] v);
        case (d)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    function automatic logic [11:0] pop_exp(input int d);
        case (d)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk_50m); while (clken !== 1'b1);
        #1;
    endtask

    // Driver: one frame, bit by bit, OVERSAMPLE ticks each. The expected word is queued first.
    task automatic send_frame(input int d, input logic [8:0] dat, input logic pbit,
                              input logic [1:0] stops, input logic exp_ovr,
                              input int post, input int gap, input bit clr_done);
        int         bits[$];
        int         os;
        int         h;
        int         f;
        logic       perr;
        logic       ferr;
        logic [8:0] dm;
        os = os_of(d);
        h  = os / 2;
        dm = dat & 9'((1 << nb_of(d)) - 1);
        bits.push_back(0);
        for (int i = 0; i < nb_of(d); i++) bits.push_back(int'(dat[i]));
        if (pm_of(d) != 0) bits.push_back(int'(pbit));
        ferr = 1'b0;
        for (int s = 0; s < ns_of(d); s++) begin
            bits.push_back(int'(stops[s]));
            if (!stops[s]) ferr = 1'b1;
        end
        perr = 1'b0;
        if (pm_of(d) != 0)
            perr = ((($countones(dm) + int'(pbit)) % 2) != ((pm_of(d) == 2) ? 1 : 0));
        push_exp(d, {exp_ovr, ferr, perr, dm});
        f = bits.size() - 1;
        wait_tick();
        for (int b = 0; b <= f; b++) begin
            rx_v[d] = (bits[b] != 0);
            for (int k = 0; k < os; k++) begin
                if (clr_done && b == f && k == h + 2) begin
                    // Acknowledge lands exactly on the final stop-bit decision tick.
                    repeat (3) @(posedge clk_50m);
                    #1 clr_man[d] = 1'b1;
                    @(posedge clk_50m);
                    #1 clr_man[d] = 1'b0;
                end else begin
                    wait_tick();
                end
            end
        end
        repeat (post) wait_tick();
        rx_v[d] = 1'b1;
        repeat (gap) wait_tick();
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (q_size(d) != 0 && n < 4000) begin
            @(posedge clk_50m);
            n++;
        end
        repeat (4) @(posedge clk_50m);
        chk($sformatf("drain_%0d", d), 32'(q_size(d)), 32'd0);
    endtask

    task automatic pulse_clr(input int d);
        @(posedge clk_50m);
        #1 clr_man[d] = 1'b1;
        @(posedge clk_50m);
        #1 clr_man[d] = 1'b0;
        @(negedge clk_50m);
    endtask

    task automatic take(input int d);
        logic [11:0] e;
        if (q_size(d) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL word_%0d: unexpected word 0x%0h, required none", d, out_v[d]);
        end else begin
            e = pop_exp(d);
            chk($sformatf("word_%0d", d), 32'(out_v[d]), 32'(e));
        end
    endtask

    // Monitor: a word is presented when rdy rises, or when outputs change while rdy stays high.
    initial begin
        logic [11:0] prev_v [3];
        logic [2:0]  rdy_q;
        clr_auto = 3'b000;
        rdy_q    = 3'b000;
        for (int d = 0; d < 3; d++) prev_v[d] = '0;
        forever begin
            @(negedge clk_50m);
            for (int d = 0; d < 3; d++) begin
                clr_auto[d] = 1'b0;
                if (rst_n === 1'b1 && rdy_v[d] === 1'b1 && (!rdy_q[d] || out_v[d] !== prev_v[d])) begin
                    take(d);
                    if (auto_clr[d]) clr_auto[d] = 1'b1;
                end
                rdy_q[d]  = rdy_v[d];
                prev_v[d] = out_v[d];
            end
        end
    end

    initial begin
        logic [8:0] rd;
        logic [1:0] st;
        rst_n    = 1'b0;
        rx_v     = 3'b111;
        clr_man  = 3'b000;
        auto_clr = 3'b111;

        repeat (4) @(posedge clk_50m);
        @(negedge clk_50m);
        for (int d = 0; d < 3; d++) chk($sformatf("reset_out_%0d", d), 32'(out_v[d]), 32'd0);
        chk("reset_rdy", 32'(rdy_v), 32'd0);
        @(posedge clk_50m);
        #1 rst_n = 1'b1;
        repeat (4) wait_tick();

        // Basic 8N1 word, then randomized words with occasional bad stop bit
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0, 0, 4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd = 9'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b11;
            send_frame(0, rd, 1'b0, st, 1'b0, 0, $urandom_range(2, 10), 1'b0);
        end
        drain(0);

        // Glitch shorter than half a bit is rejected, then a clean word follows
        wait_tick();
        rx_v[0] = 1'b0;
        repeat (8 - 2) wait_tick();
        rx_v[0] = 1'b1;
        repeat (48) wait_tick();
        chk("false_start_rdy", 32'(rdy_v[0]), 32'd0);
        send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0, 0, 4, 1'b0);
        drain(0);

        // Break: low stop bit, then line held low for 40 bit times
        send_frame(0, 9'h055, 1'b0, 2'b10, 1'b0, 40 * 16, 6, 1'b0);
        drain(0);
        send_frame(0, 9'h0C3, 1'b0, 2'b11, 1'b0, 0, 4, 1'b0);
        drain(0);

        // Overrun with no acknowledge, then acknowledge in the completion cycle
        auto_clr[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0, 0, 0, 1'b0);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b1, 0, 4, 1'b0);
        drain(0);
        chk("ovr_rdy", 32'(rdy_v[0]), 32'd1);
        chk("ovr_flag", 32'(ovr_v[0]), 32'd1);
        pulse_clr(0);
        chk("clr_rdy", 32'(rdy_v[0]), 32'd0);
        chk("clr_ovr", 32'(ovr_v[0]), 32'd0);
        chk("clr_data_hold", 32'(data_def), 32'h22);
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0, 0, 0, 1'b0);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0, 0, 4, 1'b1);
        drain(0);
        chk("ack_done_rdy", 32'(rdy_v[0]), 32'd1);
        chk("ack_done_ovr", 32'(ovr_v[0]), 32'd0);
        pulse_clr(0);
        auto_clr[0] = 1'b1;

        // Even parity: bad then good parity on the same word, then random parity bits
        send_frame(1, 9'h003, 1'b1, 2'b11, 1'b0, 0, 4, 1'b0);
        drain(1);
        chk("perr_hold_rdy", 32'(rdy_v[1]), 32'd0);
        chk("perr_hold_flag", 32'(perr_v[1]), 32'd1);
        chk("perr_hold_data", 32'(data_par), 32'h03);
        send_frame(1, 9'h003, 1'b0, 2'b11, 1'b0, 0, 4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd = 9'($urandom_range(0, 255));
            send_frame(1, rd, 1'($urandom_range(0, 1)), 2'b11, 1'b0, 0, $urandom_range(2, 10), 1'b0);
        end
        drain(1);

        // 7O2 at 8x: random words with random stop bits
        for (int i = 0; i < 6; i++) begin
            rd = 9'($urandom_range(0, 127));
            st = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send_frame(2, rd, 1'($urandom_range(0, 1)), st, 1'b0, 0, $urandom_range(2, 10), 1'b0);
        end
        drain(2);

        // Reset in the middle of data bit 3 discards the partial word
        auto_clr[2] = 1'b0;
        send_frame(2, 9'h05A, 1'b1, 2'b11, 1'b0, 0, 4, 1'b0);
        drain(2);
        chk("alt_rdy_before_rst", 32'(rdy_v[2]), 32'd1);
        wait_tick();
        rx_v[2] = 1'b0;
        repeat (8) wait_tick();
        rd = 9'h035;
        for (int b = 0; b < 3; b++) begin
            rx_v[2] = rd[b];
            repeat (8) wait_tick();
        end
        rx_v[2] = rd[3];
        repeat (4) wait_tick();
        @(posedge clk_50m);
        #1 rst_n = 1'b0;
        rx_v[2] = 1'b1;
        repeat (3) @(posedge clk_50m);
        @(negedge clk_50m);
        for (int d = 0; d < 3; d++) chk($sformatf("midrst_out_%0d", d), 32'(out_v[d]), 32'd0);
        chk("midrst_rdy", 32'(rdy_v), 32'd0);
        @(posedge clk_50m);
        #1 rst_n = 1'b1;
        auto_clr[2] = 1'b1;
        repeat (40) wait_tick();
        chk("post_rst_rdy", 32'(rdy_v[2]), 32'd0);
        send_frame(2, 9'h02B, 1'b0, 2'b11, 1'b0, 0, 4, 1'b0);
        drain(2);
        drain(0);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal 5..9.
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal 1 or 2.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, clken ticks per bit; power of two, 8..64; H = OVERSAMPLE/2.
REQ-005 SHALL have port clk_50m  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port clken  input  1  oversample tick, one clk_50m cycle wide.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rdy_clr  input  1  consumer acknowledge; clears rdy, overrun.
REQ-010 SHALL have port rdy  output  1  received word valid.
REQ-011 SHALL have port data  output  DATA_BITS  last received word, LSB = first bit on line.
REQ-012 SHALL have port parity_err  output  1  parity mismatch on word in data.
REQ-013 SHALL have port frame_err  output  1  stop bit sampled low on word in data.
REQ-014 SHALL have port overrun  output  1  word completed while rdy already set.

Function
REQ-015 SHALL pass rx through a two-flop synchronizer (reset value 1) every clk_50m cycle; all decisions use the synchronized value rx_s.
REQ-016 SHALL advance all bit timing only on cycles with clken=1; with clken=0, state, counters and sample history hold.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-018 IDLE: on a clken tick with rx_s=0 and previous-tick rx_s=1 (falling edge), SHALL enter START with tick counter cnt=0.
REQ-019 cnt SHALL count 0..OVERSAMPLE-1 on clken ticks and wrap to 0; each wrap begins the next bit.
REQ-020 Each bit value SHALL be the 2-of-3 majority of rx_s at cnt=H-1, H, H+1, decided on tick cnt=H+1.
REQ-021 START: vote 1 (false start) SHALL return to IDLE, no outputs changed; vote 0 SHALL enter DATA at next wrap.
REQ-022 DATA: SHALL shift in DATA_BITS votes LSB-first, then enter PARITY or STOP.
REQ-023 PARITY: error when XOR(data bits, parity vote) is 1 for even, 0 for odd.
REQ-024 STOP: each of STOP_BITS votes checked; any 0 sets frame error for the word; after final stop-bit decision (tick H+1) SHALL complete the word and return to IDLE that same cycle, without waiting for bit end.
REQ-025 On completion, in one cycle: data <= shifted word; parity_err, frame_err <= this word's results; rdy <= 1.
REQ-026 If rdy=1 and rdy_clr=0 at completion, overrun SHALL set to 1 (sticky); data and error flags are still overwritten.
REQ-027 rdy_clr=1 without completion SHALL clear rdy and overrun next cycle; parity_err, frame_err, data hold.
REQ-028 rdy_clr=1 in the completion cycle: rdy SHALL end at 1, overrun SHALL end at 0.
REQ-029 After a frame error, a new start SHALL require rx_s high for at least one clken tick (edge rule of REQ-018), so a held-low break yields exactly one word.
REQ-030 Latency: rdy rises exactly one clk_50m cycle after the clken tick at cnt=H+1 of the final stop bit.

Reset
REQ-031 With rst_n=0 at a clock edge: state IDLE, cnt 0, synchronizer and previous-tick sample 1, rdy 0, data all 0, parity_err 0, frame_err 0, overrun 0.
REQ-032 Reset mid-frame SHALL discard the partial word without asserting rdy; reception resumes only on a new falling edge after rst_n=1.

Verification
REQ-033 Defaults, clken every 4th cycle, frame 0xA5 8N1 -> rdy=1, data=0xA5, all error flags 0.
REQ-034 PARITY=1, 0x03 sent with parity bit 1 -> data=0x03, parity_err=1; resent with parity 0 -> parity_err=0.
REQ-035 rx low for H-2 ticks then high -> no START exit to DATA, rdy stays 0; following clean 0x3C received correctly.
REQ-036 0x55 with stop bit low -> data=0x55, frame_err=1; line held low 40 bit times -> no second word until rx returns high.
REQ-037 Two back-to-back frames 0x11, 0x22 with no rdy_clr -> data=0x22, overrun=1; repeat with rdy_clr pulsed in completion cycle of 0x22 -> rdy=1, overrun=0.
REQ-038 DATA_BITS=7, PARITY=2, STOP_BITS=2, OVERSAMPLE=8: 0x5A sent, then rst_n=0 in DATA bit 3 of next frame -> all outputs reset values, no rdy.
